// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline types and reset defaults for the fetch stage
package fetch_stage_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry FIFO with flush; entry 0 is always the head
module fetch_fifo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] m0_q, m0_d, m1_q, m1_d;
    logic [1:0]   count_q, count_d, wr_idx;
    logic         do_pop, do_push;

    always_comb begin
        do_pop  = pop && count_q != 2'd0;
        do_push = push && (count_q != 2'd2 || do_pop);
        wr_idx  = count_q - {1'b0, do_pop};
        m0_d    = do_pop ? m1_q : m0_q;
        m1_d    = m1_q;
        if (do_push && wr_idx == 2'd0) m0_d = push_data;
        if (do_push && wr_idx == 2'd1) m1_d = push_data;
        count_d = flush ? 2'd0 : count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_q    <= '0;
            m1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            m0_q    <= m0_d;
            m1_q    <= m1_d;
            count_q <= count_d;
        end
    end

    assign head  = m0_q;
    assign count = count_q;
    assign full  = count_q == 2'd2;
    assign empty = count_q == 2'd0;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a 2-slot request window, redirect flush and decode hold
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] instruction,
    output logic [31:0] pc_from_fetch,
    output logic        fetch_valid
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d, instr_q, instr_d, pc_q, pc_d, tag_pc;
    logic [1:0]   drop_q, drop_d, inflight, fifo_count;
    logic         valid_q, valid_d;
    logic         hs, resp_ok, resp_keep, load, bypass, fifo_push, fifo_pop;
    logic         tag_full, tag_empty, fifo_full, fifo_empty;
    fetch_entry_t resp_entry, head;

    // Window counts requests in flight plus buffered results, so the FIFO can never overflow
    assign imem_req_valid = state_q == RUN && !redirect_valid && !tag_full
                            && ({1'b0, inflight} + {1'b0, fifo_count} < 3'd2);
    assign imem_addr      = fetch_pc_q;

    always_comb begin
        hs         = imem_req_valid && imem_req_ready;
        resp_ok    = imem_resp_valid && !tag_empty;
        resp_keep  = resp_ok && drop_q == 2'd0 && !redirect_valid;
        load       = !valid_q || !stall;
        bypass     = load && fifo_empty && resp_keep;
        fifo_pop   = load && !fifo_empty && !redirect_valid;
        fifo_push  = resp_keep && !bypass;
        resp_entry = '{pc: tag_pc, instr: imem_resp_data};
        state_d    = RUN;
        fetch_pc_d = redirect_valid ? align_pc(redirect_pc) : hs ? fetch_pc_q + 32'd4 : fetch_pc_q;
        drop_d     = redirect_valid ? inflight - {1'b0, resp_ok}
                   : (resp_ok && drop_q != 2'd0) ? drop_q - 2'd1 : drop_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        if (redirect_valid) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = !fifo_empty || resp_keep;
            instr_d = !fifo_empty ? head.instr : resp_keep ? imem_resp_data : NOP_INSTR;
            pc_d    = !fifo_empty ? head.pc : resp_keep ? tag_pc : pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 2'd0;
            instr_q    <= NOP_INSTR;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    // Tag queue stays intact across redirects so dropped responses still pop their own tag
    fetch_fifo #(.W(32)) u_tag_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push     (hs),
        .push_data(fetch_pc_q),
        .pop      (resp_ok),
        .head     (tag_pc),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (inflight)
    );

    fetch_fifo #(.W($bits(fetch_entry_t))) u_instr_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (fifo_push),
        .push_data(resp_entry),
        .pop      (fifo_pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign instruction   = instr_q;
    assign pc_from_fetch = pc_q;
    assign fetch_valid   = valid_q;

    // Stale responses from requests abandoned by reset may still land during BOOT
    a_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
        state_q == RUN |-> !(imem_resp_valid && tag_empty));
    a_fifo_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenario bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic [31:0] instruction, pc_from_fetch;
    logic        fetch_valid;
    logic [64:0] out;
    logic [32:0] req;
    int          errors = 0;
    int          checks = 0;
    int          n_hs = 0;
    bit          mem_auto = 1'b0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instruction    (instruction),
        .pc_from_fetch  (pc_from_fetch),
        .fetch_valid    (fetch_valid)
    );

    always #5 clk = ~clk;

    assign out = {fetch_valid, pc_from_fetch, instruction};
    assign req = {imem_req_valid, imem_addr};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // One clock: optional 1-cycle-latency memory answers each handshake in the next cycle
    task automatic tick();
        logic        c;
        logic [31:0] a;
        #1;
        c = imem_req_valid && imem_req_ready;
        a = imem_addr;
        n_hs += int'(c);
        @(posedge clk);
        #1;
        if (mem_auto) begin
            imem_resp_valid = c;
            imem_resp_data  = mem_word(a);
        end
    endtask

    task automatic do_reset(input bit auto_mem);
        rst = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid = 1'b0;
        stall = 1'b0;
        imem_req_ready = 1'b1;
        mem_auto = auto_mem;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out !== {1'b0, 32'h0, NOP}) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", out, {1'b0, 32'h0, NOP});
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b expected 0", imem_req_valid);
        end
    endtask

    task automatic test_fetch_seq();
        do_reset(1'b1);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_no_req: got %b expected 0", imem_req_valid);
        end
        tick();
        checks++;
        if (req !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL first_req: got %h expected %h", req, {1'b1, 32'h0});
        end
        tick();
        checks++;
        if ({req, fetch_valid} !== {1'b1, 32'h4, 1'b0}) begin
            errors++;
            $display("FAIL second_req: got %h expected %h", {req, fetch_valid}, {1'b1, 32'h4, 1'b0});
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out !== {1'b1, 32'(4 * k), mem_word(32'(4 * k))}) begin
                errors++;
                $display("FAIL seq_%0d: got %h expected %h", k, out, {1'b1, 32'(4 * k), mem_word(32'(4 * k))});
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int          hs0;
        int          n;
        logic [31:0] exp_pc;
        do_reset(1'b1);
        repeat (3) tick();
        stall = 1'b1;
        hs0 = n_hs;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out !== {1'b1, 32'h0, mem_word(32'h0)}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %h expected %h", k, out, {1'b1, 32'h0, mem_word(32'h0)});
            end
        end
        checks++;
        if (n_hs - hs0 > 2) begin
            errors++;
            $display("FAIL stall_window: got %0d requests expected at most 2", n_hs - hs0);
        end
        stall = 1'b0;
        exp_pc = 32'h0;
        n = 0;
        for (int c = 0; c < 20 && n < 6; c++) begin
            #1;
            if (fetch_valid && !stall) begin
                checks++;
                if (out !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
                    errors++;
                    $display("FAIL stall_resume: got %h expected %h", out, {1'b1, exp_pc, mem_word(exp_pc)});
                end
                exp_pc += 32'd4;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL stall_resume_count: got %0d expected 6", n);
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (3) tick();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL window_full: got %b expected 0", imem_req_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({imem_req_valid, fetch_valid, instruction} !== {1'b0, 1'b0, NOP}) begin
            errors++;
            $display("FAIL redir_flush: got %h expected %h", {imem_req_valid, fetch_valid, instruction}, {1'b0, 1'b0, NOP});
        end
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(32'h0);
        tick();
        imem_resp_data = mem_word(32'h4);
        #1;
        checks++;
        if ({req, fetch_valid} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL redir_drop1: got %h expected %h", {req, fetch_valid}, {1'b1, 32'h100, 1'b0});
        end
        tick();
        imem_resp_data = mem_word(32'h100);
        #1;
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_drop2: got %b expected 0", fetch_valid);
        end
        tick();
        imem_resp_valid = 1'b0;
        #1;
        checks++;
        if (out !== {1'b1, 32'h100, mem_word(32'h100)}) begin
            errors++;
            $display("FAIL redir_target: got %h expected %h", out, {1'b1, 32'h100, mem_word(32'h100)});
        end
    endtask

    task automatic test_redirect_resp_stall();
        do_reset(1'b0);
        repeat (3) tick();
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(32'h0);
        tick();
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        imem_resp_data = mem_word(32'h4);
        #1;
        checks++;
        if ({imem_req_valid, out} !== {1'b0, 1'b1, 32'h0, mem_word(32'h0)}) begin
            errors++;
            $display("FAIL same_cycle_pre: got %h expected %h", {imem_req_valid, out}, {1'b0, 1'b1, 32'h0, mem_word(32'h0)});
        end
        tick();
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        checks++;
        if ({req, fetch_valid, instruction} !== {1'b1, 32'h200, 1'b0, NOP}) begin
            errors++;
            $display("FAIL same_cycle_flush: got %h expected %h", {req, fetch_valid, instruction}, {1'b1, 32'h200, 1'b0, NOP});
        end
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(32'h200);
        tick();
        imem_resp_valid = 1'b0;
        #1;
        checks++;
        if (out !== {1'b1, 32'h200, mem_word(32'h200)}) begin
            errors++;
            $display("FAIL same_cycle_nodrop: got %h expected %h", out, {1'b1, 32'h200, mem_word(32'h200)});
        end
        tick();
        checks++;
        if (out !== {1'b1, 32'h200, mem_word(32'h200)}) begin
            errors++;
            $display("FAIL same_cycle_hold: got %h expected %h", out, {1'b1, 32'h200, mem_word(32'h200)});
        end
        stall = 1'b0;
    endtask

    task automatic test_wrap_back_to_back();
        do_reset(1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (req !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL boot_redirect: got %h expected %h", req, {1'b1, 32'hFFFF_FFFC});
        end
        tick();
        checks++;
        if (req !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL pc_wrap: got %h expected %h", req, {1'b1, 32'h0});
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h400;
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        checks++;
        if ({req, fetch_valid} !== {1'b1, 32'h400, 1'b0}) begin
            errors++;
            $display("FAIL b2b_target: got %h expected %h", {req, fetch_valid}, {1'b1, 32'h400, 1'b0});
        end
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(32'h400);
        tick();
        imem_resp_valid = 1'b0;
        #1;
        checks++;
        if (out !== {1'b1, 32'h400, mem_word(32'h400)}) begin
            errors++;
            $display("FAIL b2b_drop_recompute: got %h expected %h", out, {1'b1, 32'h400, mem_word(32'h400)});
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        tick();
        redirect_valid = 1'b0;
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(32'h500);
        tick();
        imem_resp_valid = 1'b0;
        tick();
        #1;
        checks++;
        if ({imem_req_valid, fetch_valid, pc_from_fetch} !== {1'b0, 1'b0, 32'h500}) begin
            errors++;
            $display("FAIL mid_pre: got %h expected %h", {imem_req_valid, fetch_valid, pc_from_fetch}, {1'b0, 1'b0, 32'h500});
        end
        rst = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(32'h504);
        #1;
        checks++;
        if ({imem_req_valid, out} !== {1'b0, 1'b0, 32'h0, NOP}) begin
            errors++;
            $display("FAIL mid_async_reset: got %h expected %h", {imem_req_valid, out}, {1'b0, 1'b0, 32'h0, NOP});
        end
        tick();
        rst = 1'b1;
        imem_resp_data = mem_word(32'h508);
        tick();
        imem_resp_valid = 1'b0;
        #1;
        checks++;
        if ({req, fetch_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL mid_late_ignored: got %h expected %h", {req, fetch_valid}, {1'b1, 32'h0, 1'b0});
        end
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(32'h0);
        tick();
        imem_resp_valid = 1'b0;
        #1;
        checks++;
        if (out !== {1'b1, 32'h0, mem_word(32'h0)}) begin
            errors++;
            $display("FAIL mid_first_fetch: got %h expected %h", out, {1'b1, 32'h0, mem_word(32'h0)});
        end
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_stall();
        test_redirect();
        test_redirect_resp_stall();
        test_wrap_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble instruction driven when no valid instruction is held.
REQ-003 The block SHALL have the following ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- imem_req_valid  output  1  instruction-memory request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  32  request address, word aligned.
- imem_resp_valid  input  1  read data returned, in request order.
- imem_resp_data  input  32  returned instruction word.
- redirect_valid  input  1  branch/jump taken; fetch restarts at redirect_pc.
- redirect_pc  input  32  redirect target; bits [1:0] ignored and treated as 0.
- stall  input  1  downstream decode cannot accept; hold outputs.
- instruction  output  32  instruction presented to decode.
- pc_from_fetch  output  32  PC of the presented instruction.
- fetch_valid  output  1  instruction/pc_from_fetch hold a real instruction.

Function
REQ-004 The block SHALL have FSM states BOOT and RUN: BOOT is entered at reset, lasts exactly one clk cycle with no request, then moves to RUN.
REQ-005 A redirect in BOOT SHALL load fetch_pc from redirect_pc and enter RUN.
REQ-006 imem_req_valid SHALL equal (state==RUN) && !redirect_valid && (inflight + fifo_count < 2).
REQ-007 imem_addr SHALL equal fetch_pc.
REQ-008 On a handshake (imem_req_valid && imem_req_ready), the block SHALL advance fetch_pc by 4 modulo 2^32 (0xFFFF_FFFC wraps to 0), increment inflight, and push the request PC onto a 2-deep PC-tag queue.
REQ-009 On imem_resp_valid, the block SHALL decrement inflight and pop the PC-tag queue; if drop_cnt>0, it SHALL decrement drop_cnt and discard the data; otherwise it SHALL write {pc, data} into a 2-entry instruction FIFO.
REQ-010 inflight + fifo_count SHALL never exceed 2, so that the FIFO never overflows; an imem_resp_valid with inflight==0 is illegal, and an assertion SHALL flag it.
REQ-011 When fetch_valid==0 or stall==0, the output register SHALL load the FIFO head and set fetch_valid=1 if the FIFO is non-empty; otherwise it SHALL load NOP_INSTR, pc unchanged, fetch_valid=0.
REQ-012 When stall==1 && fetch_valid==1, instruction, pc_from_fetch and fetch_valid SHALL hold, and the FIFO SHALL not pop.
REQ-013 FIFO write and pop in the same cycle SHALL be allowed; a write into an empty FIFO SHALL become visible at the outputs no earlier than the next edge. Minimum latency is resp cycle to fetch_valid 1 cycle.
REQ-014 A redirect SHALL take priority over stall and over a same-cycle response; on a redirect cycle, the next edge SHALL:
- set fetch_pc to {redirect_pc[31:2],2'b00};
- flush the FIFO;
- set the output to NOP_INSTR with fetch_valid=0;
- set drop_cnt = inflight - (imem_resp_valid ? 1 : 0);
- discard any same-cycle response.
REQ-015 No request SHALL be issued in the redirect cycle; requests resume in the following cycle, and new responses SHALL be accepted only after drop_cnt reaches 0.
REQ-016 Back-to-back redirects SHALL each restart from their own target; drop_cnt SHALL be recomputed, not accumulated.

Reset
REQ-017 While rst==0, the block SHALL set the following, regardless of clk:
- state=BOOT, fetch_pc=RESET_PC;
- inflight=0, drop_cnt=0, FIFO and tag queue empty;
- instruction=NOP_INSTR, pc_from_fetch=RESET_PC, fetch_valid=0, imem_req_valid=0.
REQ-018 Reset asserted mid-operation SHALL abandon all in-flight requests; responses arriving after reset release with inflight==0 SHALL be ignored.

Structure
REQ-019 fetch_state_t (BOOT, RUN), NOP_INSTR and RESET_PC defaults SHALL live in the shared pipeline package.
REQ-020 The 2-entry {pc,instr} FIFO SHALL be a sub-module named fetch_fifo, with push/pop/full/empty/flush ports; the PC-tag queue SHALL reuse it.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- Reset release, ready=1, 1-cycle memory latency -> imem_addr 0x0,0x4,0x8...; fetch_valid first high 3 cycles after release with pc 0x0.
- stall held 3 cycles while memory stays ready -> outputs frozen, at most 2 requests outstanding/buffered, no instruction lost; sequence resumes in order.
- Redirect to 0x100 with 2 requests in flight -> both responses discarded, next fetch_valid shows pc 0x100, never pc 0x8/0xC.
- Redirect and response in the same cycle, stall=1 -> response dropped, drop_cnt=inflight-1, fetch_valid=0 next cycle.
- fetch_pc 0xFFFF_FFFC -> next imem_addr 0x0000_0000.
- rst asserted with 2 requests outstanding, then late responses -> ignored, first fetch at RESET_PC.
